// File: rtl/serial_add4b_if.sv
// Start/done handshake bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns the result.
interface serial_add4b_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_add4b.sv
// Bit-serial ripple adder: one full-adder cell reused over WIDTH cycles,
// LSB first, returning sum, carry-out and signed overflow.
module serial_add4b #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   serial_add4b_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             s_bit;
   logic             c_nxt;
   logic             accept;

   assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
   assign c_nxt  = (a_sh_q[0] & b_sh_q[0])
                 | (a_sh_q[0] & c_q)
                 | (b_sh_q[0] & c_q);
   assign accept = bus.start
                 & ((state_q == IDLE) | (state_q == DONE));

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               c_d     = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            res_d  = {s_bit, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            c_d    = c_nxt;
            cnt_d  = cnt_q + CW'(1);
            // c_q here is the carry into the MSB on the final step
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = res_d;
               cout_d  = c_nxt;
               ovf_d   = c_q ^ c_nxt;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add4b.sv
// Directed and exhaustive bench for the WIDTH=4 bit-serial adder.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_serial_add4b;
   localparam int W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_add4b_if #(.WIDTH(W)) bus ();

   serial_add4b #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Bounded wait: returns cycles to done and busy samples seen on the way
   task automatic wait_done(output int cyc, output int busy_n);
      cyc    = 0;
      busy_n = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) busy_n++;
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;
      step();
      step();
      bus.start = 1'b0;
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000",
                  {bus.busy, bus.done, bus.cout, bus.overflow});
      end
      checks++;
      if (bus.sum !== 4'd0) begin
         failures++;
         $display("FAIL reset_sum got=%0d want=0", bus.sum);
      end
   endtask

   task automatic test_basic();
      int cyc, bn;
      kick(4'd3, 4'd5, 1'b0);
      wait_done(cyc, bn);
      checks++;
      if (cyc != 4 || bn != 4) begin
         failures++;
         $display("FAIL basic_latency got=%0d/%0d want=4/4", cyc, bn);
      end
      checks++;
      if ({bus.cout, bus.overflow, bus.sum} !== {1'b0, 1'b1, 4'd8}) begin
         failures++;
         $display("FAIL basic_result got=%b%b_%0d want=01_8",
                  bus.cout, bus.overflow, bus.sum);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_pulse got=%b%b want=00", bus.done, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bn;
      kick(4'd15, 4'd1, 1'b0);
      wait_done(cyc, bn);
      checks++;
      if ({bus.cout, bus.overflow, bus.sum} !== {1'b1, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL b2b_first got=%b%b_%0d want=10_0",
                  bus.cout, bus.overflow, bus.sum);
      end
      kick(4'd7, 4'd0, 1'b1);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept got=%b%b want=01", bus.done, bus.busy);
      end
      wait_done(cyc, bn);
      checks++;
      if (cyc + 1 != 5) begin
         failures++;
         $display("FAIL b2b_spacing got=%0d want=5", cyc + 1);
      end
      checks++;
      if ({bus.cout, bus.overflow, bus.sum} !== {1'b0, 1'b1, 4'd8}) begin
         failures++;
         $display("FAIL b2b_second got=%b%b_%0d want=01_8",
                  bus.cout, bus.overflow, bus.sum);
      end
      step();
   endtask

   task automatic test_operand_change();
      int cyc, bn;
      kick(4'd9, 4'd9, 1'b1);
      bus.a   = 4'd0;
      bus.b   = 4'd0;
      bus.cin = 1'b0;
      wait_done(cyc, bn);
      checks++;
      if ({bus.cout, bus.overflow, bus.sum} !== {1'b1, 1'b1, 4'd3}) begin
         failures++;
         $display("FAIL opchg_result got=%b%b_%0d want=11_3",
                  bus.cout, bus.overflow, bus.sum);
      end
      step();
   endtask

   task automatic test_ignore_start();
      int cyc, bn, extra;
      kick(4'd6, 4'd6, 1'b0);
      bus.a     = 4'd1;
      bus.b     = 4'd1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done(cyc, bn);
      checks++;
      if (cyc + 1 != 4 || bn + 1 != 4) begin
         failures++;
         $display("FAIL ignore_latency got=%0d/%0d want=4/4", cyc + 1, bn + 1);
      end
      checks++;
      if (bus.sum !== 4'd12) begin
         failures++;
         $display("FAIL ignore_sum got=%0d want=12", bus.sum);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.busy || bus.done) extra++;
      end
      checks++;
      if (extra != 0) begin
         failures++;
         $display("FAIL ignore_requeue got=%0d want=0", extra);
      end
   endtask

   task automatic test_reset_abort();
      int cyc, bn, seen;
      kick(4'd5, 4'd2, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00 || bus.sum !== 4'd0) begin
         failures++;
         $display("FAIL abort_state got=%b%b_%0d want=00_0",
                  bus.busy, bus.done, bus.sum);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.done) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_done got=%0d want=0", seen);
      end
      kick(4'd1, 4'd1, 1'b0);
      wait_done(cyc, bn);
      checks++;
      if (cyc != 4 || bus.sum !== 4'd2) begin
         failures++;
         $display("FAIL abort_restart got=%0d_%0d want=4_2", cyc, bus.sum);
      end
      step();
   endtask

   task automatic test_sweep();
      int cyc, bn;
      logic [4:0] full;
      logic [3:0] prev;
      logic       ov;
      logic [3:0] va, vb;
      prev = bus.sum;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               va   = 4'(ia);
               vb   = 4'(ib);
               full = 5'(ia) + 5'(ib) + 5'(ic);
               ov   = (va[3] == vb[3]) && (full[3] != va[3]);
               kick(va, vb, 1'(ic));
               checks++;
               if (bus.sum !== prev) begin
                  failures++;
                  $display("FAIL sweep_hold a=%0d b=%0d got=%0d want=%0d",
                           ia, ib, bus.sum, prev);
               end
               wait_done(cyc, bn);
               checks++;
               if (cyc != 4 || {bus.cout, bus.sum} !== full
                   || bus.overflow !== ov) begin
                  failures++;
                  $display("FAIL sweep a=%0d b=%0d c=%0d got=%0d_%b want=%0d_%b",
                           ia, ib, ic, {bus.cout, bus.sum}, bus.overflow,
                           full, ov);
               end
               prev = full[3:0];
            end
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_operand_change();
      test_ignore_start();
      test_reset_abort();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
